// File: rtl/seq_divider_32x16_pkg.sv
// Shared widths and state encoding for the 32/16 sequential restoring divider.
package seq_divider_32x16_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned VW = 16;
  localparam int unsigned CW = $clog2(DW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

endpackage

// File: rtl/seq_divider_32x16_if.sv
// Operand/result handshake bundle between the arithmetic unit and the divider.
interface seq_divider_32x16_if;
  import seq_divider_32x16_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          q_ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, q_ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, q_ovf
  );

endinterface

// File: rtl/seq_divider_32x16_div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module seq_divider_32x16_div_step #(
  parameter int unsigned VW = 16
) (
  input  logic [VW-1:0] rem_in,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0] diff;

  always_comb begin
    // Partial remainder stays below the divisor, so the top bit of diff is exactly the borrow.
    diff    = {rem_in, next_bit} - {1'b0, divisor};
    q_bit   = ~diff[VW];
    rem_out = q_bit ? diff[VW-1:0] : {rem_in[VW-2:0], next_bit};
  end

endmodule

// File: rtl/seq_divider_32x16.sv
// Multi-cycle unsigned 32/16 restoring divider, one quotient bit per clock, valid/ready handshake.
module seq_divider_32x16
  import seq_divider_32x16_pkg::*;
(
  input logic                clk,
  input logic                rst,
  seq_divider_32x16_if.slave bus
);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [DW-1:0] shreg_q, shreg_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          div_zero_q, div_zero_d;
  logic          q_ovf_q, q_ovf_d;

  logic [VW-1:0] step_rem;
  logic          step_bit;
  logic [DW-1:0] quot_next;

  seq_divider_32x16_div_step #(
    .VW(VW)
  ) u_step (
    .rem_in  (rem_q),
    .next_bit(shreg_q[DW-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign quot_next = {shreg_q[DW-2:0], step_bit};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    div_zero_d = div_zero_q;
    q_ovf_d    = q_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          dvs_d      = bus.divisor;
          count_d    = CW'(DW - 1);
          div_zero_d = 1'b0;
          q_ovf_d    = 1'b0;
          if (bus.divisor == '0) begin
            shreg_d    = '1;
            rem_d      = bus.dividend[VW-1:0];
            div_zero_d = 1'b1;
            q_ovf_d    = 1'b1;
            state_d    = StDone;
          end else begin
            shreg_d = bus.dividend;
            rem_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        shreg_d = quot_next;
        rem_d   = step_rem;
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          q_ovf_d = |quot_next[DW-1:VW];
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      shreg_q    <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      div_zero_q <= 1'b0;
      q_ovf_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      div_zero_q <= div_zero_d;
      q_ovf_q    <= q_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.quotient  = shreg_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.q_ovf     = q_ovf_q;

endmodule

// File: tb/tb_seq_divider_32x16.sv
// Directed and random bench for seq_divider_32x16 against a plain-arithmetic division model.
module tb_seq_divider_32x16;
  import seq_divider_32x16_pkg::*;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  res_t        exp_res;
  logic        exp_pending = 1'b0;
  logic [31:0] got_q;
  logic [15:0] got_r;
  logic        got_dz, got_ovf;

  always #5 clk = ~clk;

  seq_divider_32x16_if bus ();

  seq_divider_32x16 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic res_t model(input logic [31:0] a, input logic [15:0] b);
    res_t m;
    if (b == 16'd0) begin
      m.q   = 32'hFFFF_FFFF;
      m.r   = a[15:0];
      m.dz  = 1'b1;
      m.ovf = 1'b1;
    end else begin
      m.q   = a / {16'h0, b};
      m.r   = 16'(a % {16'h0, b});
      m.dz  = 1'b0;
      m.ovf = (m.q > 32'h0000_FFFF);
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whenever a result is presented it must match the model and block new operands.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (!exp_pending) begin
        check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        check("quotient", 64'(bus.quotient), 64'(exp_res.q));
        check("remainder", 64'(bus.remainder), 64'(exp_res.r));
        check("div_zero", 64'(bus.div_zero), 64'(exp_res.dz));
        check("q_ovf", 64'(bus.q_ovf), 64'(exp_res.ovf));
        check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
      end
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [15:0] b, input int hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    exp_res      = model(a, b);
    exp_pending  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = 16'($urandom);
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < DW + 5) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), (b == 16'd0) ? 64'd0 : 64'(DW));
    got_q   = bus.quotient;
    got_r   = bus.remainder;
    got_dz  = bus.div_zero;
    got_ovf = bus.q_ovf;
    if (!bus.out_valid) begin
      exp_pending = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.dividend = $urandom;
      bus.divisor  = 16'($urandom);
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_pending   = 1'b0;
    @(negedge clk);
    check("drained_out_valid", 64'(bus.out_valid), 64'd0);
    check("drained_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, dvd;
    logic [15:0] b;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    check("rst_q_ovf", 64'(bus.q_ovf), 64'd0);

    run_div(32'd100, 16'd7, 5);
    check("lit_100_7_q", 64'(got_q), 64'd14);
    check("lit_100_7_r", 64'(got_r), 64'd2);
    check("lit_100_7_ovf", 64'(got_ovf), 64'd0);

    run_div(32'hFFFE_0001, 16'hFFFF, 0);
    check("lit_roundtrip_q", 64'(got_q), 64'h0000_FFFF);
    check("lit_roundtrip_r", 64'(got_r), 64'd0);
    check("lit_roundtrip_ovf", 64'(got_ovf), 64'd0);

    run_div(32'hFFFF_FFFF, 16'h0001, 1);
    check("lit_div1_q", 64'(got_q), 64'hFFFF_FFFF);
    check("lit_div1_ovf", 64'(got_ovf), 64'd1);

    run_div(32'h1234_5678, 16'h0000, 2);
    check("lit_div0_q", 64'(got_q), 64'hFFFF_FFFF);
    check("lit_div0_r", 64'(got_r), 64'h5678);
    check("lit_div0_dz", 64'(got_dz), 64'd1);

    run_div(32'd0, 16'd5, 0);
    check("lit_zero_q", 64'(got_q), 64'd0);
    check("lit_zero_r", 64'(got_r), 64'd0);

    run_div(32'd5, 16'd9, 0);
    check("lit_small_q", 64'(got_q), 64'd0);
    check("lit_small_r", 64'(got_r), 64'd5);

    // Abort a divide part-way through with reset; nothing may be presented afterwards.
    @(negedge clk);
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 16'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_quotient", 64'(bus.quotient), 64'd0);
    repeat (DW + 4) @(negedge clk);

    run_div(32'd1000, 16'd10, 0);
    check("lit_after_abort_q", 64'(got_q), 64'd100);
    check("lit_after_abort_r", 64'(got_r), 64'd0);

    for (int i = 0; i < 8; i++) begin
      a   = {16'h0, 16'($urandom_range(0, 65535))};
      b   = 16'($urandom_range(1, 65535));
      dvd = a * {16'h0, b};
      run_div(dvd, b, i % 3);
      check("product_q", 64'(got_q), 64'(a));
      check("product_r", 64'(got_r), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      dvd = $urandom;
      b   = (i == 3) ? 16'd0 : 16'($urandom_range(1, 65535) >> (i % 4) * 4);
      if (b == 16'd0 && i != 3) b = 16'd1;
      run_div(dvd, b, 0);
      if (b != 16'd0) begin
        check("invariant", 64'(got_q) * 64'(b) + 64'(got_r), 64'(dvd));
        check("rem_lt_div", 64'(got_r < b), 64'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
